tms1000_panel: RTL

Peripheral-side counterpart of the TMS1000 soft core's I/O pins. It watches the core's R strobe lines and O segment outputs and latches the segment pattern for each strobed digit into a display buffer. It refreshes that buffer onto a multiplexed, active-low LED display. It also answers the core's keyboard scan by driving the K inputs from a debounced 4×11 key matrix.

---
 rtl/tms1000_pkg.sv | 28 ++
 rtl/tms1000_key_debounce.sv | 58 +++++
 rtl/tms1000_panel.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/tms1000_pkg.sv
// Shared definitions for the TMS1000 panel peripheral.
//   - refresh_state_t : display refresh FSM encoding (BLANK = 0, DRIVE = 1)
//   - R_LINES/K_LINES : pin counts of the core's R and K ports
//   - DEF_*           : default parameter values used by the panel modules
//   - cnt_width()     : register width able to hold 0..max_val
package tms1000_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } refresh_state_t;

  localparam int R_LINES   = 11;
  localparam int K_LINES   = 4;
  localparam int KEY_COUNT = R_LINES * K_LINES;

  localparam int DEF_DIGITS         = 8;
  localparam int DEF_SETTLE_CYCLES  = 32;
  localparam int DEF_REFRESH_CYCLES = 1500;
  localparam int DEF_BLANK_CYCLES   = 60;
  localparam int DEF_SAMPLE_CYCLES  = 12000;

  // Width of a counter that must represent every value in 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tms1000_key_debounce.sv
// Key-matrix debouncer.
//   raw_clk : system clock
//   reset   : synchronous, active-high reset
//   keys    : raw asynchronous key levels, 1 = pressed
//   stable  : debounced key levels
// Each key is synchronized by two flops. Every SAMPLE_CYCLES a sample tick
// shifts the synchronized level into a 3-deep history; stable follows the key
// only once three consecutive samples agree.
module tms1000_key_debounce
  import tms1000_pkg::*;
#(
  parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES
) (
  input  logic                 raw_clk,
  input  logic                 reset,
  input  logic [KEY_COUNT-1:0] keys,
  output logic [KEY_COUNT-1:0] stable
);

  localparam int TW = cnt_width(SAMPLE_CYCLES - 1);

  logic [TW-1:0]        sample_cnt;
  logic                 tick;
  logic [KEY_COUNT-1:0] sync_1;
  logic [KEY_COUNT-1:0] sync_2;
  // hist_0 is the most recent sample, hist_1 the one before. Together with the
  // sample being taken at the tick they form the 3-bit history.
  logic [KEY_COUNT-1:0] hist_0;
  logic [KEY_COUNT-1:0] hist_1;
  logic [KEY_COUNT-1:0] all_high;
  logic [KEY_COUNT-1:0] all_low;

  assign tick     = (sample_cnt == TW'(SAMPLE_CYCLES - 1));
  assign all_high = sync_2 & hist_0 & hist_1;
  assign all_low  = ~(sync_2 | hist_0 | hist_1);

  always_ff @(posedge raw_clk) begin
    if (reset) begin
      sample_cnt <= '0;
      sync_1     <= '0;
      sync_2     <= '0;
      hist_0     <= '0;
      hist_1     <= '0;
      stable     <= '0;
    end else begin
      sync_1     <= keys;
      sync_2     <= sync_1;
      sample_cnt <= tick ? '0 : sample_cnt + TW'(1);
      if (tick) begin
        hist_0 <= sync_2;
        hist_1 <= hist_0;
        // Mixed histories hold the previous debounced level.
        stable <= (stable | all_high) & ~all_low;
      end
    end
  end

endmodule

// File: rtl/tms1000_panel.sv
// Peripheral side of the TMS1000 I/O pins: digit capture, LED refresh and
// keyboard scan response.
//   raw_clk   : system clock (12 MHz)
//   reset     : synchronous, active-high reset
//   pins_r    : R strobe outputs from the core
//   pins_o    : O segment outputs from the core
//   keys      : raw 4x11 key matrix, key (r,k) at keys[r*4+k], 1 = pressed
//   pins_k    : K inputs to the core (registered)
//   seg       : active-low segment drive, bit 6..0 = a..g, bit 7 = dp
//   digit_sel : active-low digit enables, at most one bit low
module tms1000_panel
  import tms1000_pkg::*;
#(
  parameter int DIGITS         = DEF_DIGITS,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
  parameter int BLANK_CYCLES   = DEF_BLANK_CYCLES,
  parameter int SAMPLE_CYCLES  = DEF_SAMPLE_CYCLES
) (
  input  logic                 raw_clk,
  input  logic                 reset,
  input  logic [R_LINES-1:0]   pins_r,
  input  logic [7:0]           pins_o,
  input  logic [KEY_COUNT-1:0] keys,
  output logic [K_LINES-1:0]   pins_k,
  output logic [7:0]           seg,
  output logic [DIGITS-1:0]    digit_sel
);

  localparam int SW        = cnt_width(SETTLE_CYCLES);
  localparam int PHASE_MAX = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
  localparam int TW        = cnt_width(PHASE_MAX - 1);
  localparam int IW        = cnt_width(DIGITS - 1);

  // ---------------------------------------------------------------- inputs
  logic [R_LINES-1:0] r_q;
  logic [7:0]         o_q;
  logic [SW-1:0]      settle_cnt;
  logic               settled;
  logic               input_change;

  // Comparing the pins against the register detects a change one cycle
  // earlier than comparing the register against a delayed copy, so a latch
  // lands SETTLE_CYCLES+1 cycles after the new value enters r_q/o_q.
  assign input_change = ({pins_r, pins_o} != {r_q, o_q});
  assign settled      = (settle_cnt == SW'(SETTLE_CYCLES));

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking assignments here would chain registers.
  always_ff @(posedge raw_clk) begin
    if (reset) begin
      r_q        <= '0;
      o_q        <= '0;
      settle_cnt <= '0;
    end else begin
      r_q <= pins_r;
      o_q <= pins_o;
      if (input_change)
        settle_cnt <= '0;
      else if (!settled)
        settle_cnt <= settle_cnt + SW'(1);
    end
  end

  // ---------------------------------------------------------- digit capture
  logic [7:0]        disp_buf [DIGITS];
  logic [DIGITS-1:0] arm;

  always_ff @(posedge raw_clk) begin
    if (reset) begin
      // NOTE: the display buffer is a small flop array, not RAM, and must read
      // as blank after reset, so every entry is cleared explicitly.
      for (int d = 0; d < DIGITS; d++) disp_buf[d] <= '0;
      arm <= '1;
    end else begin
      for (int d = 0; d < DIGITS; d++) begin
        if (!r_q[d]) begin
          arm[d] <= 1'b1;
        end else if (settled && arm[d]) begin
          // One latch per strobe pulse: the digit disarms until its R drops.
          disp_buf[d] <= o_q;
          arm[d]      <= 1'b0;
        end
      end
    end
  end

  // ----------------------------------------------------------- refresh FSM
  refresh_state_t state;
  logic [TW-1:0]  phase_cnt;
  logic [IW-1:0]  idx;

  always_ff @(posedge raw_clk) begin
    if (reset) begin
      state     <= BLANK;
      phase_cnt <= '0;
      idx       <= '0;
      seg       <= 8'hff;
      digit_sel <= '1;
    end else begin
      case (state)
        BLANK: begin
          if (phase_cnt == TW'(BLANK_CYCLES - 1)) begin
            state     <= DRIVE;
            phase_cnt <= '0;
            digit_sel <= ~(DIGITS'(1) << idx);
            seg       <= ~disp_buf[idx];
          end else begin
            phase_cnt <= phase_cnt + TW'(1);
          end
        end
        DRIVE: begin
          if (phase_cnt == TW'(REFRESH_CYCLES - 1)) begin
            state     <= BLANK;
            phase_cnt <= '0;
            digit_sel <= '1;
            seg       <= 8'hff;
            idx       <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
          end else begin
            phase_cnt <= phase_cnt + TW'(1);
            // Re-read every cycle so a capture during DRIVE shows up at once.
            seg       <= ~disp_buf[idx];
          end
        end
        default: state <= BLANK;
      endcase
    end
  end

  // -------------------------------------------------------------- K drive
  logic [KEY_COUNT-1:0] stable;
  logic [K_LINES-1:0]   k_next;

  tms1000_key_debounce #(
    .SAMPLE_CYCLES(SAMPLE_CYCLES)
  ) u_debounce (
    .raw_clk(raw_clk),
    .reset  (reset),
    .keys   (keys),
    .stable (stable)
  );

  // NOTE: k_next gets a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    k_next = '0;
    for (int r = 0; r < R_LINES; r++)
      for (int k = 0; k < K_LINES; k++)
        k_next[k] = k_next[k] | (r_q[r] & stable[r*K_LINES+k]);
  end

  always_ff @(posedge raw_clk) begin
    if (reset) pins_k <= '0;
    else       pins_k <= k_next;
  end

endmodule
